seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexed scan controller for the eight-digit seven-segment display that shows a 32-bit register-file word. It owns the display snapshot word and the 3-bit digit index, and feeds both to the downstream `mux_8x1` nibble selector (`D`, `sel`). It takes the selected nibble `Y` back, decodes it, and drives registered, active-low anode and segment lines. New words are accepted at any time but commit only at a frame boundary, so a scan never tears.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles each digit stays lit. Legal range is 1 or more.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `data_in`  in  32  word to display. Nibble k (bits 4k+3:4k) shows on digit k; digit 0 is rightmost.
- `load`  in  1  single-cycle strobe that captures `data_in` into the shadow register.
- `dp_in`  in  8  decimal-point request per digit, active-high. Sampled live.
- `blank_lz`  in  1  enables leading-zero blanking. Sampled at commit.
- `disp_word`  out  32  committed word. Drives the mux `D` input.
- `sel`  out  3  current digit index. Drives the mux `sel` input.
- `nib_in`  in  4  nibble returned from the mux `Y` output. Combinational, same cycle as `sel`.
- `an_n`  out  8  anode enables, active-low, one-hot-low.
- `seg_n`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `dp_n`  out  1  decimal point, active-low.
- `pending`  out  1  shadow holds a word that has not yet been committed.
- `frame_tick`  out  1  one-cycle pulse on the cycle a commit opportunity occurs, that is, when `sel` wraps from 7 to 0.

## Operation
- **Prescaler.** `div_cnt` counts 0 to REFRESH_DIV-1. On its terminal count (`adv`), `sel` increments modulo 8. With REFRESH_DIV=1, `adv` is asserted every cycle.
- **Shadow load.** When `load` is high, `shadow <= data_in` and `pending <= 1`. A second `load` before commit overwrites the shadow; only the newest word is kept.
- **Commit.** Commit happens when `adv` is high and `sel`==7, in the same cycle `sel` goes to 0. If `pending` is set, `disp_word <= shadow`, `pending <= 0`, and `lz_mask` is recomputed.
- **Load on the commit cycle.** If `load` coincides with commit, `data_in` bypasses the shadow and commits directly, and `pending` ends at 0.
- **Leading-zero mask.** `lz_mask[k]` is 1 when `blank_lz` is set, nibble k is zero, every higher nibble is zero, and k ≠ 0. Digit 0 is never blanked.
- **Output register.** Every cycle:
  - `an_n <= ~(1<<sel)`.
  - `seg_n <=` 7'h7F if `lz_mask[sel]`, otherwise `hex_to_seg(nib_in)`.
  - `dp_n <= ~dp_in[sel]`. The decimal point is shown even when the digit is blanked.
- **Segment encoding** (active-low), as `seg_n`:

  | Value | Code | Value | Code |
  |---|---|---|---|
  | 0 | 40 | 8 | 00 |
  | 1 | 79 | 9 | 10 |
  | 2 | 24 | A | 08 |
  | 3 | 30 | b | 03 |
  | 4 | 19 | C | 46 |
  | 5 | 12 | d | 21 |
  | 6 | 02 | E | 06 |
  | 7 | 78 | F | 0E |

## Timing
- **Reset values:**
  - `div_cnt` 0, `sel` 0.
  - `disp_word`, `shadow` and `lz_mask` all 0.
  - `pending` 0, `frame_tick` 0.
  - `an_n` 8'hFF, `seg_n` 7'h7F, `dp_n` 1.
  - All outputs are dark until the first clock edge after reset is released.
- **Display latency.** `an_n`/`seg_n`/`dp_n` lag `sel` by exactly 1 cycle. Anode and segment values always come from the same `sel`, so there is no ghosting.
- **Frame length** is 8×REFRESH_DIV cycles. `frame_tick` is high for 1 cycle per frame.
- **Load-to-display latency.** Worst case is 8×REFRESH_DIV+1 cycles. On the commit cycle itself it is 1 cycle to `disp_word` and 2 cycles to `seg_n` for digit 0.
- **Reset mid-frame.** All state clears immediately (asynchronous). Any shadow or pending word is lost.

## Structure
- **Package `seg_pkg`:**
  - `NUM_DIGITS`=8, `SEG_BLANK`=7'h7F.
  - The 16-entry segment constant table.
  - The function or typedef for the 7-bit segment vector.
- **Sub-module `hex_to_seg`:** purely combinational, 4-bit in, 7-bit active-low out.
- The `mux_8x1` is instantiated beside this block at the top level, not inside it.

## Test plan
All scenarios use REFRESH_DIV=4 with `mux_8x1` connected.
- **Reset.** Hold `rst_n`=0, then release. Required: `an_n`=FF, `seg_n`=7F, `dp_n`=1 during reset. `sel` steps 0,1,… every 4 cycles after release, and `disp_word`=0 shows "0" on every digit.
- **Commit and per-digit display.** `load` `data_in`=32'h89ABCDEF at cycle 5 (mid-frame). Required:
  - `pending`=1 until `sel` wraps at cycle 31, then `disp_word`=89ABCDEF and `pending`=0.
  - Digit 0 shows `seg_n`=0E with `an_n`=FE.
  - Digit 7 shows 00 with `an_n`=7F.
- **Overwrite and bypass.**
  - Two loads (11111111, then 22222222) inside one frame: only 22222222 commits.
  - A `load` of 33333333 exactly on the commit cycle: `disp_word`=33333333 next cycle, `pending`=0.
- **Leading-zero blanking.** `blank_lz`=1 with word 32'h00000A05. Required: digits 3–7 get `seg_n`=7F; digits 2, 1, 0 show 08, 40, 12.
  - With word 0, only digit 0 is lit ("0").
- **Decimal point and blanking.** `dp_in`=8'h80 with a blanked digit 7. Required: `dp_n`=0 and `seg_n`=7F while `an_n`=7F; `dp_n`=1 on all other digits.
- **Reset mid-frame.** Load a word, then assert `rst_n` with `pending`=1. Required: all outputs return to reset values asynchronously and `pending`=0. `frame_tick` pulses exactly once per 32 cycles afterwards.

Source files
------------

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants, segment table and leading-zero helper
// Purpose: segment vector type, active-low hex segment table, blanking mask.
// No ports (package).
package seg_pkg;

  localparam int NUM_DIGITS = 8;

  // Segment vector, bit order {g,f,e,d,c,b,a}, active-low.
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  // Entry n is the active-low pattern for hex value n (listed F down to 0).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // Digit k is blanked when it and every higher nibble are zero.
  // Digit 0 always stays lit so a zero word still reads "0".
  function automatic logic [NUM_DIGITS-1:0] lz_mask_of(input logic [31:0] word,
                                                       input logic blank);
    logic [NUM_DIGITS-1:0] m;
    logic                  all_zero;
    m        = '0;
    all_zero = blank;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      all_zero = all_zero & (word[4*k +: 4] == 4'h0);
      m[k]     = all_zero;
    end
    return m;
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// rtl/hex_to_seg.sv - combinational hex nibble to active-low segment decoder
// Ports:
//   nib  in  4  hex value
//   seg  out 7  segments {g,f,e,d,c,b,a}, active-low
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output seg_t       seg
);

  assign seg = SEG_TABLE[nib];

endmodule

// File: rtl/mux_8x1.sv
// rtl/mux_8x1.sv - 8-to-1 nibble selector placed beside the scan controller
// Ports:
//   D    in  32  eight nibbles, nibble k at bits 4k+3:4k
//   sel  in  3   nibble index
//   Y    out 4   selected nibble
module mux_8x1 (
  input  logic [31:0] D,
  input  logic [2:0]  sel,
  output logic [3:0]  Y
);

  assign Y = D[{sel, 2'b00} +: 4];

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - eight-digit seven-segment scan controller
// Purpose: holds the displayed word and digit index, commits new words only
// at frame boundaries, decodes the returned nibble and registers the
// active-low anode/segment/decimal-point lines.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   data_in[31:0], load   word to display and its capture strobe
//   dp_in[7:0]            per-digit decimal point request (live)
//   blank_lz              leading-zero blanking enable (sampled at commit)
//   disp_word[31:0], sel  committed word and digit index, to the nibble mux
//   nib_in[3:0]           nibble selected by the mux for the current sel
//   an_n, seg_n, dp_n     registered active-low display lines
//   pending               shadow holds an uncommitted word
//   frame_tick            one-cycle pulse when sel wraps 7 -> 0
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           data_in,
  input  logic                  load,
  input  logic [NUM_DIGITS-1:0] dp_in,
  input  logic                  blank_lz,
  output logic [31:0]           disp_word,
  output logic [2:0]            sel,
  input  logic [3:0]            nib_in,
  output logic [NUM_DIGITS-1:0] an_n,
  output seg_t                  seg_n,
  output logic                  dp_n,
  output logic                  pending,
  output logic                  frame_tick
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [DIV_W-1:0]      div_cnt;
  logic [31:0]           shadow;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  adv;
  logic                  commit;
  seg_t                  seg_dec;

  assign adv    = (div_cnt == DIV_W'(REFRESH_DIV - 1));
  assign commit = adv && (sel == 3'd7);

  hex_to_seg u_hex_to_seg (
    .nib (nib_in),
    .seg (seg_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      sel     <= '0;
    end else begin
      div_cnt <= adv ? '0 : div_cnt + DIV_W'(1);
      if (adv) sel <= sel + 3'd1;
    end
  end

  // A load on the commit cycle goes straight to disp_word so the newest
  // word is never held back a whole extra frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow     <= '0;
      pending    <= 1'b0;
      disp_word  <= '0;
      lz_mask    <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= commit;
      if (load) shadow <= data_in;
      if (commit && load) begin
        disp_word <= data_in;
        lz_mask   <= lz_mask_of(data_in, blank_lz);
        pending   <= 1'b0;
      end else if (commit && pending) begin
        disp_word <= shadow;
        lz_mask   <= lz_mask_of(shadow, blank_lz);
        pending   <= 1'b0;
      end else if (load) begin
        pending   <= 1'b1;
      end
    end
  end

  // Anode, segment and decimal point all register from the same sel value,
  // so a digit change never shows the previous digit's segments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_n  <= '1;
      seg_n <= SEG_BLANK;
      dp_n  <= 1'b1;
    end else begin
      an_n  <= ~(NUM_DIGITS'(1) << sel);
      seg_n <= lz_mask[sel] ? SEG_BLANK : seg_dec;
      dp_n  <= ~dp_in[sel];
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl with mux_8x1
module tb_seg_scan_ctrl;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data_in = '0;
  logic        load = 1'b0;
  logic [7:0]  dp_in = '0;
  logic        blank_lz = 1'b0;
  logic [31:0] disp_word;
  logic [2:0]  sel;
  logic [3:0]  nib;
  logic [7:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        pending;
  logic        frame_tick;

  seg_scan_ctrl #(.REFRESH_DIV(DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .load       (load),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .disp_word  (disp_word),
    .sel        (sel),
    .nib_in     (nib),
    .an_n       (an_n),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .pending    (pending),
    .frame_tick (frame_tick)
  );

  mux_8x1 u_mux (
    .D   (disp_word),
    .sel (sel),
    .Y   (nib)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
  } obs_t;

  typedef struct {
    logic [31:0]     word;
    logic            blank;
    logic [7:0]      dp;
    logic [7:0][6:0] seg;
  } vec_t;

  obs_t sb_q[$];
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (frame_tick) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL frame_tick_timeout actual=0 required=1");
    end
  endtask

  task automatic pulse_load(input logic [31:0] w);
    data_in = w;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   first_tick;
    int   n_ticks;
    obs_t e;

    vecs[0] = '{32'h89ABCDEF, 1'b0, 8'h00,
                {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}};
    vecs[1] = '{32'h00000A05, 1'b1, 8'h00,
                {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h40, 7'h12}};
    vecs[2] = '{32'h00000000, 1'b1, 8'h80,
                {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vecs[3] = '{32'h01234567, 1'b0, 8'h01,
                {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78}};
    vecs[4] = '{32'h00000000, 1'b0, 8'h55,
                {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};
    vecs[5] = '{32'h80000000, 1'b1, 8'h00,
                {7'h00, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};
    vecs[6] = '{32'h000C0000, 1'b1, 8'h00,
                {7'h7F, 7'h7F, 7'h7F, 7'h46, 7'h40, 7'h40, 7'h40, 7'h40}};

    // Reset values, then prescaled sel stepping from release.
    step(3);
    chk("rst_an_n", an_n, 8'hFF);
    chk("rst_seg_n", seg_n, 7'h7F);
    chk("rst_dp_n", dp_n, 1'b1);
    chk("rst_pending", pending, 1'b0);
    chk("rst_sel", sel, 3'd0);
    chk("rst_disp_word", disp_word, 32'h0);
    rst_n = 1'b1;
    step(1);
    chk("post_rst_an_n", an_n, 8'hFE);
    chk("post_rst_seg_n_zero", seg_n, 7'h40);
    chk("post_rst_dp_n", dp_n, 1'b1);
    step(2);
    chk("sel_edge3", sel, 3'd0);
    step(1);
    chk("sel_edge4", sel, 3'd1);
    step(4);
    chk("sel_edge8", sel, 3'd2);

    // Table: load mid-frame, commit at the wrap, then one full scan.
    for (int v = 0; v < 7; v++) begin
      wait_tick();
      step(3);
      blank_lz = vecs[v].blank;
      dp_in    = vecs[v].dp;
      pulse_load(vecs[v].word);
      chk($sformatf("v%0d_pending_after_load", v), pending, 1'b1);
      for (int k = 0; k < 8; k++) begin
        e.an  = ~(8'h01 << k);
        e.seg = vecs[v].seg[k];
        e.dp  = ~vecs[v].dp[k];
        sb_q.push_back(e);
      end
      wait_tick();
      chk($sformatf("v%0d_disp_word", v), disp_word, vecs[v].word);
      chk($sformatf("v%0d_pending_after_commit", v), pending, 1'b0);
      for (int k = 0; k < 8; k++) begin
        step(k == 0 ? 2 : 4);
        if (sb_q.size() == 0) begin
          chk("scoreboard_underflow", 0, 1);
        end else begin
          e = sb_q.pop_front();
          chk($sformatf("v%0d_d%0d_an_n", v, k), an_n, e.an);
          chk($sformatf("v%0d_d%0d_seg_n", v, k), seg_n, e.seg);
          chk($sformatf("v%0d_d%0d_dp_n", v, k), dp_n, e.dp);
        end
      end
    end
    chk("scoreboard_empty", sb_q.size(), 0);

    // Two loads within one frame: only the newer word commits.
    blank_lz = 1'b0;
    dp_in    = 8'h00;
    wait_tick();
    step(2);
    pulse_load(32'h11111111);
    step(3);
    pulse_load(32'h22222222);
    chk("ovw_pending", pending, 1'b1);
    wait_tick();
    chk("ovw_disp_word", disp_word, 32'h22222222);
    chk("ovw_pending_clear", pending, 1'b0);

    // Load exactly on the commit edge bypasses the shadow.
    step(31);
    data_in = 32'h33333333;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
    chk("byp_frame_tick", frame_tick, 1'b1);
    chk("byp_disp_word", disp_word, 32'h33333333);
    chk("byp_pending", pending, 1'b0);
    step(1);
    chk("byp_d0_an_n", an_n, 8'hFE);
    chk("byp_d0_seg_n", seg_n, 7'h30);

    // Reset mid-frame with a word pending.
    step(2);
    pulse_load(32'h44444444);
    chk("mid_pending_before_rst", pending, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_an_n", an_n, 8'hFF);
    chk("mid_rst_seg_n", seg_n, 7'h7F);
    chk("mid_rst_dp_n", dp_n, 1'b1);
    chk("mid_rst_pending", pending, 1'b0);
    chk("mid_rst_disp_word", disp_word, 32'h0);
    chk("mid_rst_sel", sel, 3'd0);
    chk("mid_rst_frame_tick", frame_tick, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    first_tick = 0;
    n_ticks    = 0;
    for (int i = 1; i <= 96; i++) begin
      @(negedge clk);
      if (frame_tick) begin
        n_ticks++;
        if (first_tick == 0) first_tick = i;
      end
    end
    chk("mid_tick_count", n_ticks, 3);
    chk("mid_first_tick_cycle", first_tick, 32);
    chk("mid_shadow_lost_disp_word", disp_word, 32'h0);
    chk("mid_shadow_lost_pending", pending, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
